axi_llc_burst_splitter: RTL and testbench
=========================================

// Module: axi_llc_burst_splitter
// PURPOSE
//  Sequential, handshaked successor of the LLC burst cutter. Accepts one AXI AW/AR burst per transaction
//  and emits one descriptor per cache line touched, one per cycle, under valid/ready back-pressure.
//  Adds WRAP-burst splitting, parametrised line/data/way geometry and per-descriptor SPM/error decode.
//  Sits between the LLC Ax slave port and the descriptor spill register feeding the config/hit-miss stage.
// PARAMETERS
//  AddrWidth  64  address width in bits
//  IdWidth    6   AXI ID width
//  DataBytes  8   AXI data bus width in bytes (power of 2); max legal size = log2(DataBytes)
//  LineBytes  64  cache line size in bytes (power of 2, >= DataBytes)
//  NumWays    8   set associativity; one SPM window per way
//  WayBytes   32768  bytes per SPM way window (power of 2)
//  Write      0   value driven on desc_rw_o (0 = AR, 1 = AW)
// PORTS
//  clk_i         in   1          clock, rising edge
//  rst_i         in   1          synchronous reset, active high
//  ax_valid_i    in   1          burst valid
//  ax_ready_o    out  1          burst accepted when valid & ready
//  ax_id_i       in   IdWidth    burst ID
//  ax_addr_i     in   AddrWidth  start address
//  ax_len_i      in   8          AXI len (beats-1)
//  ax_size_i     in   3          AXI size
//  ax_burst_i    in   2          AXI burst type
//  cached_start_i/cached_end_i  in  AddrWidth  cached region [start, end)
//  spm_start_i   in   AddrWidth  base of SPM region (NumWays*WayBytes long)
//  desc_valid_o  out  1          descriptor valid
//  desc_ready_i  in   1          descriptor consumed when valid & ready
//  desc_id_o / desc_addr_o / desc_size_o  out  IdWidth / AddrWidth / 3  copied/segment values
//  desc_len_o    out  8          beats-1 of this segment
//  desc_burst_o  out  2          INCR for split segments; original type otherwise
//  desc_last_o   out  1          final descriptor of the burst
//  desc_spm_o    out  1          SPM (or error) access
//  desc_way_o    out  NumWays    one-hot way for SPM access, 0 otherwise
//  desc_err_o    out  1          decode error / illegal size (SLVERR)
//  desc_rw_o     out  1          = Write
//  busy_o        out  1          burst held (state SPLIT)
// BEHAVIOUR
//  - Reset: state IDLE; desc_valid_o=0, ax_ready_o=1 in IDLE, busy_o=0; all desc_* data regs 0.
//  - States: IDLE -> SPLIT on ax handshake (burst registered; first descriptor valid next cycle, latency 1).
//    SPLIT -> IDLE on handshake with desc_last_o=1. Reset mid-burst discards the remainder, no descriptor issued.
//  - ax_ready_o = IDLE | (desc_valid_o & desc_ready_i & desc_last_o): back-to-back bursts, zero bubble.
//  - desc_* held stable while desc_valid_o & !desc_ready_i. At most one descriptor per cycle.
//  - Segment arithmetic on current address a, remaining len L (AddrWidth wide, no truncation):
//    nxt = (a & ~(LineBytes-1)) + LineBytes; beats = ((nxt-a-1) >> size)+1;
//    if beats-1 < L: desc_len=beats-1, a<=nxt, L<=L-beats, last=0; else desc_len=L, last=1.
//  - FIXED: single descriptor, len unchanged, burst FIXED, last=1.
//  - WRAP: container C=(len+1)<<size, base B=a & ~(C-1). If C<=LineBytes: single descriptor, burst WRAP.
//    Else split as INCR; when nxt would equal B+C, next address is B (wrap). Total beats preserved.
//  - Decode per descriptor on its own address: a in [spm_start, spm_start+NumWays*WayBytes) -> spm=1,
//    way=1<<((a-spm_start)/WayBytes); else a in cached region -> spm=0, way=0; else spm=1, way=1, err=1.
//    SPM match wins over cached overlap.
//  - size > log2(DataBytes): err=1, spm=1, way=1, burst emitted as one descriptor, last=1.
//  - Address rollover past 2^AddrWidth in INCR: treated as decode error on the wrapped segment (err=1).
// TESTING
//  - INCR addr 0x1038, size 3, len 3 -> desc (0x1038,len0,last0), (0x1040,len2,last1); 2 cycles, ready=1.
//  - WRAP addr 0x10F0, size 3, len 15 (C=128) -> (0x10F0,len1,INCR), (0x1080,len7), (0x10C0,len5,last1).
//  - WRAP addr 0x2008, size 2, len 3 (C=16) -> single desc addr 0x2008 len 3 burst WRAP last1.
//  - FIXED len 255 across line -> single desc len 255 last1; addr outside all rules -> err1 spm1 way=1.
//  - SPM: spm_start 0x8000_0000, addr 0x8000_8000, WayBytes 0x8000 -> spm1 way=0b10; ready low 5 cycles,
//    outputs stable; burst accepted same cycle as prior last handshake; rst_i mid-split -> valid=0 next cycle.

Source files
------------

// File: rtl/axi_llc_burst_splitter.sv
// Splits one AXI AW/AR burst into one descriptor per touched cache line.
// Descriptors are emitted one per cycle under valid/ready back-pressure.
// WRAP bursts whose container exceeds a line are split as INCR segments.
// Each descriptor is decoded on its own address: SPM way window, cached
// region, or decode error.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ax_*                          burst request with valid/ready handshake
//   cached_start_i/cached_end_i   cached region [start, end)
//   spm_start_i                   SPM base (NumWays*WayBytes long)
//   desc_*                        per-line descriptor with valid/ready handshake
//   busy_o                        a burst is being split
module axi_llc_burst_splitter #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 6,
  parameter int unsigned DataBytes = 8,
  parameter int unsigned LineBytes = 64,
  parameter int unsigned NumWays   = 8,
  parameter int unsigned WayBytes  = 32768,
  parameter bit          Write     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ax_valid_i,
  output logic                 ax_ready_o,
  input  logic [IdWidth-1:0]   ax_id_i,
  input  logic [AddrWidth-1:0] ax_addr_i,
  input  logic [7:0]           ax_len_i,
  input  logic [2:0]           ax_size_i,
  input  logic [1:0]           ax_burst_i,
  input  logic [AddrWidth-1:0] cached_start_i,
  input  logic [AddrWidth-1:0] cached_end_i,
  input  logic [AddrWidth-1:0] spm_start_i,
  output logic                 desc_valid_o,
  input  logic                 desc_ready_i,
  output logic [IdWidth-1:0]   desc_id_o,
  output logic [AddrWidth-1:0] desc_addr_o,
  output logic [2:0]           desc_size_o,
  output logic [7:0]           desc_len_o,
  output logic [1:0]           desc_burst_o,
  output logic                 desc_last_o,
  output logic                 desc_spm_o,
  output logic [NumWays-1:0]   desc_way_o,
  output logic                 desc_err_o,
  output logic                 desc_rw_o,
  output logic                 busy_o
);

  localparam int unsigned DataLog = $clog2(DataBytes);
  localparam int unsigned WayLog  = $clog2(WayBytes);

  localparam logic [AddrWidth-1:0] LineSz   = AddrWidth'(LineBytes);
  localparam logic [AddrWidth-1:0] LineMask = AddrWidth'(LineBytes - 1);
  localparam logic [AddrWidth-1:0] SpmSize  = AddrWidth'(NumWays * WayBytes);
  localparam logic [AddrWidth-1:0] One      = AddrWidth'(1);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic {
    IDLE,
    SPLIT
  } state_e;

  state_e state_q, state_d;

  // Remaining-burst bookkeeping
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] len_q, len_d;
  logic [2:0]           size_q, size_d;
  logic                 wrap_q, wrap_d;
  logic [AddrWidth-1:0] wbase_q, wbase_d;
  logic [AddrWidth-1:0] wend_q, wend_d;
  logic                 roll_q, roll_d;

  // Registered descriptor outputs
  logic                 desc_valid_q, desc_valid_d;
  logic [IdWidth-1:0]   desc_id_q, desc_id_d;
  logic [AddrWidth-1:0] desc_addr_q, desc_addr_d;
  logic [2:0]           desc_size_q, desc_size_d;
  logic [7:0]           desc_len_q, desc_len_d;
  logic [1:0]           desc_burst_q, desc_burst_d;
  logic                 desc_last_q, desc_last_d;
  logic                 desc_spm_q, desc_spm_d;
  logic [NumWays-1:0]   desc_way_q, desc_way_d;
  logic                 desc_err_q, desc_err_d;

  logic                 desc_hs, accept, advance;
  logic [AddrWidth-1:0] in_c, in_base;
  logic                 in_bad, in_single, in_wrap_split;

  logic [AddrWidth-1:0] src_addr, src_len, src_wbase, src_wend;
  logic [2:0]           src_size;
  logic                 src_wrap, src_roll;

  logic [AddrWidth-1:0] seg_nxt, seg_beats, seg_next_addr;
  logic                 seg_last, seg_next_roll;

  logic [AddrWidth-1:0] spm_off;
  logic                 dec_spm, dec_err;
  logic [NumWays-1:0]   dec_way;

  always_comb begin
    desc_hs    = desc_valid_q & desc_ready_i;
    ax_ready_o = (state_q == IDLE) | (desc_hs & desc_last_q);
    accept     = ax_valid_i & ax_ready_o;
    advance    = desc_hs & ~desc_last_q;
  end

  // Classification of the incoming burst
  always_comb begin
    in_c          = (AddrWidth'(ax_len_i) + One) << ax_size_i;
    in_base       = ax_addr_i & ~(in_c - One);
    in_bad        = ax_size_i > 3'(DataLog);
    in_single     = (ax_burst_i == BurstFixed) |
                    ((ax_burst_i == BurstWrap) & (in_c <= LineSz));
    in_wrap_split = (ax_burst_i == BurstWrap) & ~in_single;
  end

  // Segment source: the new burst on accept, otherwise the stored remainder
  always_comb begin
    src_addr  = accept ? ax_addr_i : addr_q;
    src_len   = accept ? AddrWidth'(ax_len_i) : len_q;
    src_size  = accept ? ax_size_i : size_q;
    src_wrap  = accept ? in_wrap_split : wrap_q;
    src_wbase = accept ? in_base : wbase_q;
    src_wend  = accept ? (in_base + in_c) : wend_q;
    src_roll  = accept ? 1'b0 : roll_q;
  end

  // Line segment arithmetic; a wrapped INCR segment starts at address 0
  always_comb begin
    seg_nxt       = (src_addr & ~LineMask) + LineSz;
    seg_beats     = ((seg_nxt - src_addr - One) >> src_size) + One;
    seg_last      = seg_beats > src_len;
    seg_next_addr = (src_wrap && (seg_nxt == src_wend)) ? src_wbase : seg_nxt;
    seg_next_roll = src_roll | (~src_wrap & (seg_nxt == '0));
  end

  // Address decode; SPM window takes priority over a cached overlap
  always_comb begin
    spm_off = src_addr - spm_start_i;
    dec_spm = 1'b1;
    dec_way = NumWays'(1);
    dec_err = 1'b1;
    if (!src_roll) begin
      if ((src_addr >= spm_start_i) && (spm_off < SpmSize)) begin
        dec_way = NumWays'(1) << (spm_off >> WayLog);
        dec_err = 1'b0;
      end else if ((src_addr >= cached_start_i) && (src_addr < cached_end_i)) begin
        dec_spm = 1'b0;
        dec_way = '0;
        dec_err = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    wrap_d       = wrap_q;
    wbase_d      = wbase_q;
    wend_d       = wend_q;
    roll_d       = roll_q;
    desc_valid_d = desc_valid_q;
    desc_id_d    = desc_id_q;
    desc_addr_d  = desc_addr_q;
    desc_size_d  = desc_size_q;
    desc_len_d   = desc_len_q;
    desc_burst_d = desc_burst_q;
    desc_last_d  = desc_last_q;
    desc_spm_d   = desc_spm_q;
    desc_way_d   = desc_way_q;
    desc_err_d   = desc_err_q;

    if (accept || advance) begin
      state_d      = SPLIT;
      desc_valid_d = 1'b1;
      desc_addr_d  = src_addr;
      desc_size_d  = src_size;
      desc_spm_d   = dec_spm;
      desc_way_d   = dec_way;
      desc_err_d   = dec_err;
      if (accept) begin
        desc_id_d = ax_id_i;
      end
      if (accept && (in_bad || in_single)) begin
        desc_len_d   = ax_len_i;
        desc_burst_d = ax_burst_i;
        desc_last_d  = 1'b1;
        if (in_bad) begin
          desc_spm_d = 1'b1;
          desc_way_d = NumWays'(1);
          desc_err_d = 1'b1;
        end
      end else begin
        desc_len_d   = seg_last ? src_len[7:0] : 8'(seg_beats - One);
        desc_burst_d = BurstIncr;
        desc_last_d  = seg_last;
        addr_d       = seg_next_addr;
        len_d        = src_len - seg_beats;
        size_d       = src_size;
        wrap_d       = src_wrap;
        wbase_d      = src_wbase;
        wend_d       = src_wend;
        roll_d       = seg_next_roll;
      end
    end else if (desc_hs) begin
      state_d      = IDLE;
      desc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      wrap_q       <= 1'b0;
      wbase_q      <= '0;
      wend_q       <= '0;
      roll_q       <= 1'b0;
      desc_valid_q <= 1'b0;
      desc_id_q    <= '0;
      desc_addr_q  <= '0;
      desc_size_q  <= '0;
      desc_len_q   <= '0;
      desc_burst_q <= '0;
      desc_last_q  <= 1'b0;
      desc_spm_q   <= 1'b0;
      desc_way_q   <= '0;
      desc_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      wrap_q       <= wrap_d;
      wbase_q      <= wbase_d;
      wend_q       <= wend_d;
      roll_q       <= roll_d;
      desc_valid_q <= desc_valid_d;
      desc_id_q    <= desc_id_d;
      desc_addr_q  <= desc_addr_d;
      desc_size_q  <= desc_size_d;
      desc_len_q   <= desc_len_d;
      desc_burst_q <= desc_burst_d;
      desc_last_q  <= desc_last_d;
      desc_spm_q   <= desc_spm_d;
      desc_way_q   <= desc_way_d;
      desc_err_q   <= desc_err_d;
    end
  end

  assign desc_valid_o = desc_valid_q;
  assign desc_id_o    = desc_id_q;
  assign desc_addr_o  = desc_addr_q;
  assign desc_size_o  = desc_size_q;
  assign desc_len_o   = desc_len_q;
  assign desc_burst_o = desc_burst_q;
  assign desc_last_o  = desc_last_q;
  assign desc_spm_o   = desc_spm_q;
  assign desc_way_o   = desc_way_q;
  assign desc_err_o   = desc_err_q;
  assign desc_rw_o    = Write;
  assign busy_o       = (state_q == SPLIT);

endmodule

// File: tb/tb_axi_llc_burst_splitter.sv
// Directed bench for axi_llc_burst_splitter with hand-computed expectations.
module tb_axi_llc_burst_splitter;

  logic        clk;
  logic        rst;
  logic        ax_valid;
  logic        ax_ready;
  logic [5:0]  ax_id;
  logic [63:0] ax_addr;
  logic [7:0]  ax_len;
  logic [2:0]  ax_size;
  logic [1:0]  ax_burst;
  logic [63:0] cached_start;
  logic [63:0] cached_end;
  logic [63:0] spm_start;
  logic        desc_valid;
  logic        desc_ready;
  logic [5:0]  desc_id;
  logic [63:0] desc_addr;
  logic [2:0]  desc_size;
  logic [7:0]  desc_len;
  logic [1:0]  desc_burst;
  logic        desc_last;
  logic        desc_spm;
  logic [7:0]  desc_way;
  logic        desc_err;
  logic        desc_rw;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  axi_llc_burst_splitter #(
    .AddrWidth (64),
    .IdWidth   (6),
    .DataBytes (8),
    .LineBytes (64),
    .NumWays   (8),
    .WayBytes  (32768),
    .Write     (1'b0)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ax_valid_i     (ax_valid),
    .ax_ready_o     (ax_ready),
    .ax_id_i        (ax_id),
    .ax_addr_i      (ax_addr),
    .ax_len_i       (ax_len),
    .ax_size_i      (ax_size),
    .ax_burst_i     (ax_burst),
    .cached_start_i (cached_start),
    .cached_end_i   (cached_end),
    .spm_start_i    (spm_start),
    .desc_valid_o   (desc_valid),
    .desc_ready_i   (desc_ready),
    .desc_id_o      (desc_id),
    .desc_addr_o    (desc_addr),
    .desc_size_o    (desc_size),
    .desc_len_o     (desc_len),
    .desc_burst_o   (desc_burst),
    .desc_last_o    (desc_last),
    .desc_spm_o     (desc_spm),
    .desc_way_o     (desc_way),
    .desc_err_o     (desc_err),
    .desc_rw_o      (desc_rw),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a burst for one cycle; the DUT must be ready when it is offered.
  task automatic send(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    ax_id    = id;
    ax_addr  = addr;
    ax_len   = len;
    ax_size  = size;
    ax_burst = burst;
    ax_valid = 1'b1;
    #1;
    chk("ax_ready_on_send", 64'(ax_ready), 64'd1);
    tick();
    ax_valid = 1'b0;
  endtask

  // Check the descriptor currently presented, then let one clock edge pass.
  task automatic expect_desc(input string tag, input logic [5:0] id, input logic [63:0] addr,
                             input logic [7:0] len, input logic [1:0] burst, input logic last,
                             input logic spm, input logic [7:0] way, input logic err);
    chk({tag, "_valid"}, 64'(desc_valid), 64'd1);
    chk({tag, "_id"},    64'(desc_id),    64'(id));
    chk({tag, "_addr"},  desc_addr,       addr);
    chk({tag, "_len"},   64'(desc_len),   64'(len));
    chk({tag, "_burst"}, 64'(desc_burst), 64'(burst));
    chk({tag, "_last"},  64'(desc_last),  64'(last));
    chk({tag, "_spm"},   64'(desc_spm),   64'(spm));
    chk({tag, "_way"},   64'(desc_way),   64'(way));
    chk({tag, "_err"},   64'(desc_err),   64'(err));
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    ax_valid     = 1'b0;
    ax_id        = '0;
    ax_addr      = '0;
    ax_len       = '0;
    ax_size      = '0;
    ax_burst     = '0;
    desc_ready   = 1'b1;
    cached_start = 64'h0;
    cached_end   = 64'h4000_0000;
    spm_start    = 64'h8000_0000;

    tick();
    tick();
    chk("rst_valid",    64'(desc_valid), 64'd0);
    chk("rst_busy",     64'(busy),       64'd0);
    chk("rst_ax_ready", 64'(ax_ready),   64'd1);
    chk("rst_addr",     desc_addr,       64'd0);
    chk("rst_len",      64'(desc_len),   64'd0);
    chk("rst_way",      64'(desc_way),   64'd0);
    chk("rw",           64'(desc_rw),    64'd0);
    rst = 1'b0;
    tick();

    // INCR crossing one line boundary
    send(6'd1, 64'h1038, 8'd3, 3'd3, 2'b01);
    chk("incr_busy", 64'(busy), 64'd1);
    chk("incr_size", 64'(desc_size), 64'd3);
    expect_desc("incr0", 6'd1, 64'h1038, 8'd0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    expect_desc("incr1", 6'd1, 64'h1040, 8'd2, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("incr_done_valid", 64'(desc_valid), 64'd0);
    chk("incr_done_busy",  64'(busy),       64'd0);

    // WRAP with 128-byte container: split as INCR, wraps to base
    send(6'd2, 64'h10F0, 8'd15, 3'd3, 2'b10);
    expect_desc("wrap0", 6'd2, 64'h10F0, 8'd1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    expect_desc("wrap1", 6'd2, 64'h1080, 8'd7, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    expect_desc("wrap2", 6'd2, 64'h10C0, 8'd5, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("wrap_done_valid", 64'(desc_valid), 64'd0);

    // WRAP within a line: single WRAP descriptor
    send(6'd3, 64'h2008, 8'd3, 3'd2, 2'b10);
    chk("wsmall_size", 64'(desc_size), 64'd2);
    expect_desc("wsmall", 6'd3, 64'h2008, 8'd3, 2'b10, 1'b1, 1'b0, 8'h00, 1'b0);

    // FIXED across a line, outside every region -> decode error
    send(6'd4, 64'h9000_0038, 8'd255, 3'd3, 2'b00);
    expect_desc("fixed", 6'd4, 64'h9000_0038, 8'd255, 2'b00, 1'b1, 1'b1, 8'h01, 1'b1);
    chk("fixed_done_valid", 64'(desc_valid), 64'd0);

    // SPM way 1 under back-pressure, then back-to-back burst
    desc_ready = 1'b0;
    send(6'd5, 64'h8000_8000, 8'd1, 3'd3, 2'b01);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",    64'(desc_valid), 64'd1);
      chk("bp_addr",     desc_addr,       64'h8000_8000);
      chk("bp_len",      64'(desc_len),   64'd1);
      chk("bp_last",     64'(desc_last),  64'd1);
      chk("bp_spm",      64'(desc_spm),   64'd1);
      chk("bp_way",      64'(desc_way),   64'h02);
      chk("bp_err",      64'(desc_err),   64'd0);
      chk("bp_ax_ready", 64'(ax_ready),   64'd0);
      tick();
    end
    ax_id      = 6'd6;
    ax_addr    = 64'h1000;
    ax_len     = 8'd0;
    ax_size    = 3'd3;
    ax_burst   = 2'b01;
    ax_valid   = 1'b1;
    desc_ready = 1'b1;
    #1;
    chk("b2b_ax_ready", 64'(ax_ready), 64'd1);
    tick();
    ax_valid = 1'b0;
    expect_desc("b2b", 6'd6, 64'h1000, 8'd0, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("b2b_done_valid", 64'(desc_valid), 64'd0);

    // Size above bus width: single error descriptor
    send(6'd7, 64'h1000, 8'd3, 3'd4, 2'b01);
    expect_desc("badsize", 6'd7, 64'h1000, 8'd3, 2'b01, 1'b1, 1'b1, 8'h01, 1'b1);

    // Reset in the middle of a long split
    send(6'd8, 64'h1000, 8'd255, 3'd0, 2'b01);
    expect_desc("mid0", 6'd8, 64'h1000, 8'd63, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("mid1_addr", desc_addr, 64'h1040);
    chk("mid1_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("midrst_valid",    64'(desc_valid), 64'd0);
    chk("midrst_busy",     64'(busy),       64'd0);
    chk("midrst_ax_ready", 64'(ax_ready),   64'd1);
    rst = 1'b0;
    tick();
    chk("midrst_idle_valid", 64'(desc_valid), 64'd0);

    // INCR rolling over the top of the address space
    spm_start = 64'hFFFF_FFFF_FFFC_0000;
    send(6'd9, 64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 2'b01);
    expect_desc("roll0", 6'd9, 64'hFFFF_FFFF_FFFF_FFF8, 8'd0, 2'b01, 1'b0, 1'b1, 8'h80, 1'b0);
    expect_desc("roll1", 6'd9, 64'h0, 8'd0, 2'b01, 1'b1, 1'b1, 8'h01, 1'b1);
    chk("roll_done_valid", 64'(desc_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
